// File: rtl/axi4_lite_modport_regs_pkg.sv
// axi4_lite_modport_regs_pkg: response codes, lane constant and address-decode helpers.
// Macro AXI4_LITE_MODPORT_REGS_SLVERR_EN: when defined, out-of-range accesses answer SLVERR.
package axi4_lite_modport_regs_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Byte-lane LSB for a 32-bit bus; a 64-bit bus adds one.
    localparam int ADDR_LSB = 2;

`ifdef AXI4_LITE_MODPORT_REGS_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    function automatic int unsigned reg_index(input logic [63:0] addr, input int lsb, input int num_regs);
        return 32'((addr >> lsb) & (64'(num_regs) - 64'd1));
    endfunction

    // In range when every bit above the index field is zero.
    function automatic bit in_range(input logic [63:0] addr, input int top_lsb);
        return (addr >> top_lsb) == 64'd0;
    endfunction

    function automatic resp_t access_resp(input bit ok);
        return (ok || !SLVERR_EN) ? OKAY : SLVERR;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite signal bundle with master and slave modports.
interface axi4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32
);
    logic [ADDR_BIT_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [DATA_BIT_WIDTH-1:0]   wdata;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [ADDR_BIT_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport slv_port (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport mst_port (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

// File: rtl/axi4_lite_modport_regs_wr_join.sv
// axi4_lite_modport_regs_wr_join: buffers AW and W independently, pairs them into a commit, owns the B channel.
// Ports: i_aw*/o_awready, i_w*/o_wready, o_bvalid/o_bresp/i_bready bus side;
//        o_commit (in-range register write strobe), o_idx, o_data, o_strb toward the register array.
module axi4_lite_modport_regs_wr_join
    import axi4_lite_modport_regs_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int NUM_REGS       = 4,
    parameter int LSB            = ADDR_LSB
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [ADDR_BIT_WIDTH-1:0]    i_awaddr,
    input  logic                         i_awvalid,
    output logic                         o_awready,
    input  logic [DATA_BIT_WIDTH-1:0]    i_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0]  i_wstrb,
    input  logic                         i_wvalid,
    output logic                         o_wready,
    output logic                         o_bvalid,
    output logic [1:0]                   o_bresp,
    input  logic                         i_bready,
    output logic                         o_commit,
    output logic [$clog2(NUM_REGS)-1:0]  o_idx,
    output logic [DATA_BIT_WIDTH-1:0]    o_data,
    output logic [DATA_BIT_WIDTH/8-1:0]  o_strb
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                        r_aw_full;
    logic                        r_w_full;
    logic [ADDR_BIT_WIDTH-1:0]   r_awaddr;
    logic [DATA_BIT_WIDTH-1:0]   r_wdata;
    logic [DATA_BIT_WIDTH/8-1:0] r_wstrb;
    logic                        w_aw_hs;
    logic                        w_w_hs;
    logic                        w_commit;
    logic                        w_in_range;
    logic                        w_aw_full_n;
    logic                        w_w_full_n;
    logic                        w_bvalid_n;
    logic [ADDR_BIT_WIDTH-1:0]   w_awaddr;

    // A handshake in this cycle counts as a full buffer, so a same-edge AW+W commits immediately.
    always_comb begin
        w_aw_hs     = i_awvalid & o_awready;
        w_w_hs      = i_wvalid & o_wready;
        w_awaddr    = r_aw_full ? r_awaddr : i_awaddr;
        o_data      = r_w_full ? r_wdata : i_wdata;
        o_strb      = r_w_full ? r_wstrb : i_wstrb;
        w_in_range  = in_range(64'(w_awaddr), LSB + IDX_W);
        o_idx       = IDX_W'(reg_index(64'(w_awaddr), LSB, NUM_REGS));
        w_commit    = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs) & ~o_bvalid;
        o_commit    = w_commit & w_in_range;
        w_aw_full_n = ~w_commit & (r_aw_full | w_aw_hs);
        w_w_full_n  = ~w_commit & (r_w_full | w_w_hs);
        w_bvalid_n  = w_commit | (o_bvalid & ~i_bready);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            o_bvalid  <= 1'b0;
            o_bresp   <= OKAY;
        end else begin
            r_aw_full <= w_aw_full_n;
            r_w_full  <= w_w_full_n;
            if (w_aw_hs) r_awaddr <= i_awaddr;
            if (w_w_hs) begin
                r_wdata <= i_wdata;
                r_wstrb <= i_wstrb;
            end
            o_awready <= ~w_aw_full_n & ~w_bvalid_n;
            o_wready  <= ~w_w_full_n & ~w_bvalid_n;
            o_bvalid  <= w_bvalid_n;
            if (w_commit) o_bresp <= access_resp(w_in_range);
        end
    end
endmodule

// File: rtl/axi4_lite_modport_regs.sv
// axi4_lite_modport_regs: AXI4-Lite slave register file of NUM_REGS data-width registers.
// Ports: i_clk, i_rst (async, active-high), if_s_axi (axi4_lite_if.slv_port),
//        o_regs (register k at [k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH]).
// Macro AXI4_LITE_MODPORT_REGS_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi4_lite_modport_regs
    import axi4_lite_modport_regs_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int NUM_REGS       = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    axi4_lite_if.slv_port                      if_s_axi,
    output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] o_regs
);
    localparam int LSB    = (DATA_BIT_WIDTH == 64) ? ADDR_LSB + 1 : ADDR_LSB;
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_BIT_WIDTH / 8;

    logic [DATA_BIT_WIDTH-1:0] r_regs [NUM_REGS];
    logic                      w_commit;
    logic [IDX_W-1:0]          w_widx;
    logic [DATA_BIT_WIDTH-1:0] w_wdata;
    logic [STRB_W-1:0]         w_wstrb;
    logic                      w_ar_hs;
    logic                      w_ar_in_range;
    logic                      w_rvalid_n;
    logic [IDX_W-1:0]          w_ridx;
    logic                      w_unused;

    // Protection bits carry no meaning for this block.
    assign w_unused = ^{if_s_axi.awprot, if_s_axi.arprot};

    axi4_lite_modport_regs_wr_join #(
        .ADDR_BIT_WIDTH (ADDR_BIT_WIDTH),
        .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
        .NUM_REGS       (NUM_REGS),
        .LSB            (LSB)
    ) u_wr_join (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_awaddr  (if_s_axi.awaddr),
        .i_awvalid (if_s_axi.awvalid),
        .o_awready (if_s_axi.awready),
        .i_wdata   (if_s_axi.wdata),
        .i_wstrb   (if_s_axi.wstrb),
        .i_wvalid  (if_s_axi.wvalid),
        .o_wready  (if_s_axi.wready),
        .o_bvalid  (if_s_axi.bvalid),
        .o_bresp   (if_s_axi.bresp),
        .i_bready  (if_s_axi.bready),
        .o_commit  (w_commit),
        .o_idx     (w_widx),
        .o_data    (w_wdata),
        .o_strb    (w_wstrb)
    );

    always_comb begin
        w_ar_hs       = if_s_axi.arvalid & if_s_axi.arready;
        w_ridx        = IDX_W'(reg_index(64'(if_s_axi.araddr), LSB, NUM_REGS));
        w_ar_in_range = in_range(64'(if_s_axi.araddr), LSB + IDX_W);
        w_rvalid_n    = w_ar_hs | (if_s_axi.rvalid & ~if_s_axi.rready);
    end

    // Read data samples r_regs before this edge's write lands, so a colliding read sees the old value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_regs           <= '{default: '0};
            if_s_axi.arready <= 1'b0;
            if_s_axi.rvalid  <= 1'b0;
            if_s_axi.rdata   <= '0;
            if_s_axi.rresp   <= OKAY;
        end else begin
            if (w_commit) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (w_wstrb[i]) r_regs[w_widx][i*8 +: 8] <= w_wdata[i*8 +: 8];
                end
            end
            if_s_axi.arready <= ~w_rvalid_n;
            if_s_axi.rvalid  <= w_rvalid_n;
            if (w_ar_hs) begin
                if_s_axi.rdata <= w_ar_in_range ? r_regs[w_ridx] : '0;
                if_s_axi.rresp <= access_resp(w_ar_in_range);
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign o_regs[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = r_regs[k];
    end
endmodule

// File: tb/tb_axi4_lite_modport_regs.sv
// tb_axi4_lite_modport_regs: directed and randomized bus traffic checked against a register-array model.
`timescale 1ns/1ps
module tb_axi4_lite_modport_regs;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] regs;
    int           n_vec = 0;
    int           n_err = 0;
    logic [31:0]  m_regs [4];
    logic [31:0]  rd;
    logic [1:0]   rr;
    logic [1:0]   br;
    logic [31:0]  old_val;
    logic [31:0]  a;

`ifdef AXI4_LITE_MODPORT_REGS_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    axi4_lite_if u_if ();

    axi4_lite_modport_regs u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .if_s_axi (u_if),
        .o_regs   (regs)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    function automatic bit m_in_range(input logic [31:0] addr);
        return addr < 32'h10;
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] addr);
        return m_in_range(addr) ? 2'b00 : OOR_RESP;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        return m_in_range(addr) ? m_regs[addr / 4] : 32'h0;
    endfunction

    task automatic m_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (m_in_range(addr)) m_regs[addr / 4] = (m_regs[addr / 4] & ~mask) | (d & mask);
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < 4; k++) check($sformatf("%s_reg%0d", tag, k), regs[k*32 +: 32], m_regs[k]);
    endtask

    // Presents AW from cycle aw_at and W from cycle w_at; returns #1 after the later handshake edge.
    task automatic aw_w(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                        input int aw_at, input int w_at);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs;
        bit w_hs;
        int c = 0;
        u_if.awprot = 3'($urandom);
        while (!(aw_done && w_done) && c < 100) begin
            @(negedge clk);
            u_if.awaddr  = addr;
            u_if.wdata   = d;
            u_if.wstrb   = s;
            u_if.awvalid = !aw_done && c >= aw_at;
            u_if.wvalid  = !w_done && c >= w_at;
            #1;
            aw_hs = u_if.awvalid && u_if.awready;
            w_hs  = u_if.wvalid && u_if.wready;
            check("b_early", u_if.bvalid, 1'b0);
            @(posedge clk);
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            c++;
        end
        check("aw_w_done", aw_done && w_done, 1'b1);
        #1;
        check("b_lat", u_if.bvalid, 1'b1);
    endtask

    task automatic b_take(input int hold, output logic [1:0] resp);
        @(negedge clk);
        u_if.awvalid = 1'b0;
        u_if.wvalid  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            check("b_hold", u_if.bvalid, 1'b1);
            check("awready_hold", u_if.awready, 1'b0);
            check("wready_hold", u_if.wready, 1'b0);
            @(negedge clk);
        end
        u_if.bready = 1'b1;
        #1;
        resp = u_if.bresp;
        check("b_valid", u_if.bvalid, 1'b1);
        @(posedge clk);
        #1;
        check("b_drop", u_if.bvalid, 1'b0);
        check("awready_after_b", u_if.awready, 1'b1);
        @(negedge clk);
        u_if.bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                            input int aw_at, input int w_at, input int hold);
        logic [1:0] resp;
        aw_w(addr, d, s, aw_at, w_at);
        m_write(addr, d, s);
        check_regs("wr");
        b_take(hold, resp);
        check("bresp", resp, m_resp(addr));
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        int c = 0;
        @(negedge clk);
        u_if.araddr  = addr;
        u_if.arprot  = 3'($urandom);
        u_if.arvalid = 1'b1;
        #1;
        while (!u_if.arready && c < 100) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("arready", u_if.arready, 1'b1);
        @(posedge clk);
        #1;
        check("r_lat", u_if.rvalid, 1'b1);
        @(negedge clk);
        u_if.arvalid = 1'b0;
        data = u_if.rdata;
        for (int i = 0; i < hold; i++) begin
            check("r_hold", u_if.rvalid, 1'b1);
            check("rdata_stable", u_if.rdata, data);
            check("arready_hold", u_if.arready, 1'b0);
            @(negedge clk);
        end
        u_if.rready = 1'b1;
        #1;
        data = u_if.rdata;
        resp = u_if.rresp;
        @(posedge clk);
        #1;
        check("r_drop", u_if.rvalid, 1'b0);
        @(negedge clk);
        check("arready_back", u_if.arready, 1'b1);
        u_if.rready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, u_if.awready, 1'b0);
        check({tag, "_wready"}, u_if.wready, 1'b0);
        check({tag, "_bvalid"}, u_if.bvalid, 1'b0);
        check({tag, "_bresp"}, u_if.bresp, 2'b00);
        check({tag, "_arready"}, u_if.arready, 1'b0);
        check({tag, "_rvalid"}, u_if.rvalid, 1'b0);
        check({tag, "_rdata"}, u_if.rdata, 32'h0);
        check({tag, "_rresp"}, u_if.rresp, 2'b00);
        for (int k = 0; k < 4; k++) m_regs[k] = 32'h0;
        check_regs(tag);
    endtask

    initial begin
        rst          = 1'b1;
        u_if.awaddr  = '0;
        u_if.awprot  = '0;
        u_if.awvalid = 1'b0;
        u_if.wdata   = '0;
        u_if.wstrb   = '0;
        u_if.wvalid  = 1'b0;
        u_if.bready  = 1'b0;
        u_if.araddr  = '0;
        u_if.arprot  = '0;
        u_if.arvalid = 1'b0;
        u_if.rready  = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            do_read(32'(k * 4), 0, rd, rr);
            check("init_rdata", rd, 32'h0);
            check("init_rresp", rr, 2'b00);
        end

        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check("full_word", regs[63:32], 32'hDEADBEEF);
        do_read(32'h4, 0, rd, rr);
        check("full_word_rd", rd, 32'hDEADBEEF);

        do_write(32'h0, 32'h11223344, 4'hF, 0, 0, 0);
        do_write(32'h0, 32'hAABBCCDD, 4'h5, 0, 0, 0);
        check("byte_strobe", regs[31:0], 32'h11BB33DD);

        do_write(32'h8, 32'h0BADCAFE, 4'hF, 3, 0, 4);
        do_write(32'hC, 32'h5A5A5A5A, 4'hF, 0, 2, 1);

        do_write(32'h10, 32'h12345678, 4'hF, 0, 0, 0);
        do_read(32'h10, 0, rd, rr);
        check("oor_rdata", rd, 32'h0);
        check("oor_rresp", rr, OOR_RESP);

        do_read(32'h8, 3, rd, rr);
        check("rbp_rdata", rd, 32'h0BADCAFE);

        old_val = m_regs[1];
        fork
            do_write(32'h4, 32'h13579BDF, 4'hF, 0, 0, 0);
            do_read(32'h4, 0, rd, rr);
        join
        check("collide_old", rd, old_val);
        do_read(32'h4, 0, rd, rr);
        check("collide_new", rd, m_regs[1]);

        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                do_read(a, $urandom_range(0, 2), rd, rr);
                check("rnd_rdata", rd, m_read(a));
                check("rnd_rresp", rr, m_resp(a));
            end
        end

        aw_w(32'h8, 32'hCAFEF00D, 4'hF, 0, 0);
        m_write(32'h8, 32'hCAFEF00D, 4'hF);
        check_regs("pre_rst");
        @(negedge clk);
        u_if.awvalid = 1'b0;
        u_if.wvalid  = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_read(32'h8, 0, rd, rr);
        check("post_rst_rdata", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
